div_radix2: RTL and testbench
=============================

Name: div_radix2

Overview:
- Multi-cycle 32-bit integer divider for DIV/DIVU in the execute stage.
- It produces the ready handshake that the hazard unit uses to build the divider stall (stall_divE = div op in E and not ready).
- Radix-2 restoring algorithm, one quotient bit per cycle.
- Holds its result until the stalled pipeline lets the instruction leave E, so other stall sources (i_stall/d_stall) cannot make it restart.

Parameters:
- WIDTH, 32, operand width; quotient and remainder are each WIDTH bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start_i  input  1  DIV/DIVU occupies E and the instruction is not being flushed.
- signed_div_i  input  1  1 = DIV (signed), 0 = DIVU.
- opdata1_i  input  WIDTH  dividend (rs).
- opdata2_i  input  WIDTH  divisor (rt).
- stall_i  input  1  stallE from the hazard unit (longest_stall).
- annul_i  input  1  flushE / exception flush; aborts the operation.
- result_o  output  2*WIDTH  {remainder (HI), quotient (LO)}.
- ready_o  output  1  result valid; the hazard unit reads it as ready_oE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state = IDLE, counter = 0, result register = 0. Hence ready_o = 0 and result_o = 0.
- States: IDLE, BYZERO, ON, END (encodings in the shared header).
- ready_o = (state == END), decoded combinationally from the state register. result_o is driven from the result register.
- annul_i has priority over every transition except rst. Any state goes to IDLE, counter is cleared, result is unchanged, and no ready pulse occurs.
- IDLE:
  - start_i = 1 and opdata2_i = 0 → BYZERO.
  - start_i = 1 and opdata2_i ≠ 0 → ON.
  - On entry to ON, latch |dividend| and |divisor| (two's-complement absolute value only when signed_div_i = 1), both operand signs, and signed_div_i. Clear counter and partial remainder.
  - Operand changes after this latch are ignored.
- BYZERO: the result register is loaded with 0 → END. Divide-by-zero is defined as a zero result; no exception is raised here.
- ON, each cycle:
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor; if the result is non-negative, keep it and set quotient bit = 1, otherwise restore and set quotient bit = 0.
  - Increment counter. After iteration WIDTH (counter = WIDTH), → END.
  - On the END transition, apply sign correction when signed: negate the quotient if the operand signs differ; the remainder takes the sign of the dividend.
  - Load the result register with {rem, quot}.
- Latency: start_i seen in IDLE in cycle 0 → ready_o first high in cycle 33 (WIDTH+1). Divide-by-zero → ready_o high in cycle 2.
- END:
  - ready_o = 1, result held.
  - stall_i = 1 → stay in END (the instruction is still in E).
  - stall_i = 0 → IDLE on this edge (the instruction advances). ready_o is 0 the next cycle.
- Back-to-back divides: the second DIV enters E while the block is in IDLE and starts normally. There is no extra bubble beyond the IDLE cycle.
- start_i dropping while in ON (without annul): the operation continues to END. END then exits on stall_i = 0.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wraps).
- Width rules:
  - Internal partial remainder is WIDTH+1 bits.
  - Subtraction is unsigned on absolute values.
  - Negation is two's complement on WIDTH bits.

Decomposition:
- Shared defines header (the one holding DIV_CONTROL/DIVU_CONTROL): add DIV_IDLE, DIV_BYZERO, DIV_ON and DIV_END state codes (2 bits), and DIV_RESULT_READY/NOT_READY.
- Sub-module: none required. The datapath (abs, shift-subtract, sign fix) stays inline.

Test Plan:
- Unsigned divide, no stalls: DIVU 7/2, start_i held, stall_i = 0 → ready_o = 1 in cycle 33; result_o = {0x00000001, 0x00000003}; IDLE next cycle.
- Signed divide and overflow:
  - DIV 0xFFFFFFF9 (-7) / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Divide by zero: DIV 5/0 → ready_o = 1 in cycle 2, result_o = 0.
- Hold under external stall: stall_i = 1 for 4 cycles after ready_o rises → ready_o stays 1 and result_o stays stable, with no restart. stall_i = 0 → ready_o = 0 next cycle; a new DIV in the following cycle completes normally.
- Abort: annul_i = 1 in cycle 10 of an ON sequence → IDLE next cycle, ready_o never asserts. Likewise rst = 1 mid-ON → ready_o = 0 and result_o = 0 next cycle.
- Operand isolation: change opdata1_i and opdata2_i every cycle after start → result matches the values latched at start.

Source files
------------

// File: rtl/div_radix2_pkg.sv
// ----------------------------------------------------------------------------
// div_radix2_pkg
// Shared definitions for the execute-stage divider and its users.
//   - ALU control codes that select DIV / DIVU in the execute stage
//   - Divider FSM state codes (2 bits)
//   - Ready / not-ready levels seen by the hazard unit
// No ports: this is a package.
// ----------------------------------------------------------------------------
package div_radix2_pkg;

   localparam logic [7:0] DIV_CONTROL  = 8'b0001_1010;
   localparam logic [7:0] DIVU_CONTROL = 8'b0001_1011;

   typedef enum logic [1:0] {
      DIV_IDLE   = 2'b00,
      DIV_BYZERO = 2'b01,
      DIV_ON     = 2'b10,
      DIV_END    = 2'b11
   } divState_t;

   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_radix2_if.sv
// ----------------------------------------------------------------------------
// div_radix2_if
// Groups the divider's request/response signals between the execute stage
// (master) and the divider (slave).
//   start_i      : DIV/DIVU sits in E and is not being flushed
//   signed_div_i : 1 = DIV, 0 = DIVU
//   opdata1_i    : dividend (rs)
//   opdata2_i    : divisor (rt)
//   stall_i      : stallE from the hazard unit
//   annul_i      : flushE / exception flush, aborts the divide
//   result_o     : {remainder (HI), quotient (LO)}
//   ready_o      : result valid, used by the hazard unit to build stall_divE
// ----------------------------------------------------------------------------
interface div_radix2_if #(
   parameter int WIDTH = 32
);

   logic               start_i;
   logic               signed_div_i;
   logic [WIDTH-1:0]   opdata1_i;
   logic [WIDTH-1:0]   opdata2_i;
   logic               stall_i;
   logic               annul_i;
   logic [2*WIDTH-1:0] result_o;
   logic               ready_o;

   // Pipeline side: issues the request and consumes the result.
   modport master (
      output start_i,
      output signed_div_i,
      output opdata1_i,
      output opdata2_i,
      output stall_i,
      output annul_i,
      input  result_o,
      input  ready_o
   );

   // Divider side.
   modport slave (
      input  start_i,
      input  signed_div_i,
      input  opdata1_i,
      input  opdata2_i,
      input  stall_i,
      input  annul_i,
      output result_o,
      output ready_o
   );

endinterface

// File: rtl/div_radix2.sv
// ----------------------------------------------------------------------------
// div_radix2
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the execute stage.
// One quotient bit is produced per cycle; a divide takes WIDTH+1 cycles from
// the start request to ready, a divide by zero takes 2 cycles and yields 0.
// The result is held in END for as long as the pipeline stalls, so other
// stall sources cannot make the divide restart.
// Ports:
//   clk    : system clock, rising edge
//   rst    : synchronous active-high reset
//   divBus : div_radix2_if slave modport (request, operands, stall, annul,
//            result and ready)
// ----------------------------------------------------------------------------
module div_radix2
   import div_radix2_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input logic         clk,
   input logic         rst,
   div_radix2_if.slave divBus
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   divState_t          r_state;
   divState_t          w_nextState;

   logic [CNT_W-1:0]   r_count;
   logic [WIDTH:0]     r_partRem;
   logic [WIDTH-1:0]   r_dividend;
   logic [WIDTH-1:0]   r_divisor;
   logic               r_signedOp;
   logic               r_dividendNeg;
   logic               r_divisorNeg;
   logic [2*WIDTH-1:0] r_result;

   logic [WIDTH-1:0]   w_absDividend;
   logic [WIDTH-1:0]   w_absDivisor;
   logic [WIDTH:0]     w_shift;
   logic [WIDTH:0]     w_sub;
   logic               w_ge;
   logic [WIDTH:0]     w_newRem;
   logic [WIDTH-1:0]   w_quotAbs;
   logic [WIDTH-1:0]   w_quotFix;
   logic [WIDTH-1:0]   w_remFix;
   logic               w_lastIter;

   // Magnitudes of the incoming operands. DIVU operands are already
   // unsigned, so the absolute value is only taken for signed DIV.
   assign w_absDividend = (divBus.signed_div_i && divBus.opdata1_i[WIDTH-1]) ?
                          -divBus.opdata1_i : divBus.opdata1_i;
   assign w_absDivisor  = (divBus.signed_div_i && divBus.opdata2_i[WIDTH-1]) ?
                          -divBus.opdata2_i : divBus.opdata2_i;

   // One restoring step. The dividend register doubles as the quotient
   // register: its MSB feeds the partial remainder and the new quotient bit
   // enters at the LSB. The partial remainder is one bit wider than the
   // operands so the shifted value can never overflow before the compare.
   assign w_shift    = (r_partRem << 1) | {{WIDTH{1'b0}}, r_dividend[WIDTH-1]};
   assign w_sub      = w_shift - {1'b0, r_divisor};
   assign w_ge       = (w_shift >= {1'b0, r_divisor});
   assign w_newRem   = w_ge ? w_sub : w_shift;
   assign w_quotAbs  = {r_dividend[WIDTH-2:0], w_ge};
   assign w_lastIter = (r_count == LAST_ITER);

   // Sign correction applied on the way into the result register: the
   // quotient is negative when the operand signs differ and the remainder
   // follows the dividend. The most-negative / -1 case wraps back to itself.
   assign w_quotFix = (r_signedOp && (r_dividendNeg ^ r_divisorNeg)) ?
                      -w_quotAbs : w_quotAbs;
   assign w_remFix  = (r_signedOp && r_dividendNeg) ?
                      -w_newRem[WIDTH-1:0] : w_newRem[WIDTH-1:0];

   // State register for the divider FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= DIV_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. Annul wins over everything but reset so a flushed
   // divide never raises ready. END only leaves once the pipeline stops
   // stalling, which is when the instruction actually moves out of E.
   always_comb begin
      w_nextState = r_state;
      if (divBus.annul_i) begin
         w_nextState = DIV_IDLE;
      end else begin
         case (r_state)
            DIV_IDLE: begin
               if (divBus.start_i) begin
                  if (divBus.opdata2_i == '0) begin
                     w_nextState = DIV_BYZERO;
                  end else begin
                     w_nextState = DIV_ON;
                  end
               end
            end
            DIV_BYZERO: begin
               w_nextState = DIV_END;
            end
            DIV_ON: begin
               if (w_lastIter) begin
                  w_nextState = DIV_END;
               end
            end
            DIV_END: begin
               if (!divBus.stall_i) begin
                  w_nextState = DIV_IDLE;
               end
            end
            default: begin
               w_nextState = DIV_IDLE;
            end
         endcase
      end
   end

   // Datapath registers. Operands are captured once on entry to ON and the
   // live inputs are ignored afterwards. An annul only clears the counter;
   // the previous result stays visible on result_o.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count       <= '0;
         r_partRem     <= '0;
         r_dividend    <= '0;
         r_divisor     <= '0;
         r_signedOp    <= 1'b0;
         r_dividendNeg <= 1'b0;
         r_divisorNeg  <= 1'b0;
         r_result      <= '0;
      end else if (divBus.annul_i) begin
         r_count <= '0;
      end else begin
         case (r_state)
            DIV_IDLE: begin
               if (divBus.start_i && (divBus.opdata2_i != '0)) begin
                  r_dividend    <= w_absDividend;
                  r_divisor     <= w_absDivisor;
                  r_dividendNeg <= divBus.opdata1_i[WIDTH-1];
                  r_divisorNeg  <= divBus.opdata2_i[WIDTH-1];
                  r_signedOp    <= divBus.signed_div_i;
                  r_partRem     <= '0;
                  r_count       <= '0;
               end
            end
            DIV_BYZERO: begin
               r_result <= '0;
            end
            DIV_ON: begin
               r_partRem  <= w_newRem;
               r_dividend <= w_quotAbs;
               r_count    <= r_count + CNT_W'(1);
               if (w_lastIter) begin
                  r_result <= {w_remFix, w_quotFix};
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Ready is a pure decode of the state register so the hazard unit sees
   // it early in the cycle.
   assign divBus.ready_o  = (r_state == DIV_END) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
   assign divBus.result_o = r_result;

endmodule

// File: tb/tb_div_radix2.sv
// ----------------------------------------------------------------------------
// tb_div_radix2
// Directed bench for div_radix2: drives the divider through div_radix2_if and
// compares ready/result against hand-computed values.
// ----------------------------------------------------------------------------
module tb_div_radix2;

   logic clk;
   logic rst;
   int   nAsserts;
   int   nFails;
   logic [63:0] heldResult;
   logic        sawReady;

   div_radix2_if #(.WIDTH(32)) divBus ();

   div_radix2 #(.WIDTH(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .divBus (divBus)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one cycle; inputs change and outputs are sampled 1 ns after
   // the rising edge.
   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Drive every divider input at once.
   task automatic applyStimulus(input logic start, input logic sgn,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic stall, input logic annul);
      divBus.start_i      = start;
      divBus.signed_div_i = sgn;
      divBus.opdata1_i    = a;
      divBus.opdata2_i    = b;
      divBus.stall_i      = stall;
      divBus.annul_i      = annul;
   endtask

   // Single comparison point.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      nAsserts++;
      assert (observed === expected)
      else begin
         nFails++;
         $error("[TB] FAIL %s: observed=0x%h expected=0x%h", tag, observed, expected);
      end
   endtask

   // Full divide with stall_i low: start held from cycle 0, ready expected
   // low in cycle 32, high in cycle 33, low again in cycle 34.
   task automatic runDiv(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] expected);
      applyStimulus(1'b1, sgn, a, b, 1'b0, 1'b0);
      repeat (32) stepCycle();
      checkOutput({tag, "_notReady32"}, {63'b0, divBus.ready_o}, 64'd0);
      stepCycle();
      checkOutput({tag, "_ready33"}, {63'b0, divBus.ready_o}, 64'd1);
      checkOutput({tag, "_result"}, divBus.result_o, expected);
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      stepCycle();
      checkOutput({tag, "_idleNext"}, {63'b0, divBus.ready_o}, 64'd0);
   endtask

   // Directed sequence.
   initial begin
      nAsserts = 0;
      nFails   = 0;
      rst      = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      repeat (2) stepCycle();
      checkOutput("reset_ready", {63'b0, divBus.ready_o}, 64'd0);
      checkOutput("reset_result", divBus.result_o, 64'd0);
      rst = 1'b0;
      stepCycle();

      $display("[TB] unsigned and signed divides");
      runDiv("divu_7_2", 1'b0, 32'd7, 32'd2, {32'h0000_0001, 32'h0000_0003});
      runDiv("divu_big", 1'b0, 32'hFFFF_FFF9, 32'd2, {32'h0000_0001, 32'h7FFF_FFFC});
      runDiv("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      runDiv("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000});

      $display("[TB] divide by zero");
      applyStimulus(1'b1, 1'b1, 32'd5, 32'd0, 1'b0, 1'b0);
      stepCycle();
      checkOutput("byzero_cycle1", {63'b0, divBus.ready_o}, 64'd0);
      stepCycle();
      checkOutput("byzero_cycle2", {63'b0, divBus.ready_o}, 64'd1);
      checkOutput("byzero_result", divBus.result_o, 64'd0);
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      stepCycle();
      checkOutput("byzero_idle", {63'b0, divBus.ready_o}, 64'd0);

      $display("[TB] hold under external stall");
      applyStimulus(1'b1, 1'b0, 32'd100, 32'd7, 1'b1, 1'b0);
      repeat (33) stepCycle();
      checkOutput("stall_ready33", {63'b0, divBus.ready_o}, 64'd1);
      checkOutput("stall_result", divBus.result_o, {32'd2, 32'd14});
      heldResult = divBus.result_o;
      for (int i = 0; i < 3; i++) begin
         stepCycle();
         checkOutput("stall_holdReady", {63'b0, divBus.ready_o}, 64'd1);
         checkOutput("stall_holdResult", divBus.result_o, {32'd2, 32'd14});
      end
      stepCycle();
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      checkOutput("stall_releaseReady", {63'b0, divBus.ready_o}, 64'd1);
      stepCycle();
      checkOutput("stall_releasedIdle", {63'b0, divBus.ready_o}, 64'd0);
      runDiv("div_after_stall", 1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2});

      $display("[TB] annul mid-divide");
      applyStimulus(1'b1, 1'b0, 32'd1000, 32'd10, 1'b0, 1'b0);
      repeat (10) stepCycle();
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      stepCycle();
      checkOutput("annul_readyNext", {63'b0, divBus.ready_o}, 64'd0);
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      sawReady = 1'b0;
      for (int i = 0; i < 30; i++) begin
         stepCycle();
         sawReady = sawReady | divBus.ready_o;
      end
      checkOutput("annul_neverReady", {63'b0, sawReady}, 64'd0);
      checkOutput("annul_resultKept", divBus.result_o, {32'hFFFF_FFFE, 32'hFFFF_FFF2});

      $display("[TB] reset mid-divide");
      applyStimulus(1'b1, 1'b0, 32'd9, 32'd3, 1'b0, 1'b0);
      repeat (10) stepCycle();
      rst = 1'b1;
      stepCycle();
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      checkOutput("rstMid_ready", {63'b0, divBus.ready_o}, 64'd0);
      checkOutput("rstMid_result", divBus.result_o, 64'd0);
      stepCycle();

      $display("[TB] operand isolation");
      applyStimulus(1'b1, 1'b1, 32'h1234_5678, 32'h0000_0123, 1'b0, 1'b0);
      for (int i = 0; i < 32; i++) begin
         stepCycle();
         divBus.opdata1_i    = $urandom;
         divBus.opdata2_i    = $urandom;
         divBus.signed_div_i = ~divBus.signed_div_i;
      end
      stepCycle();
      checkOutput("isolate_ready", {63'b0, divBus.ready_o}, 64'd1);
      checkOutput("isolate_result", divBus.result_o, {32'h0000_0108, 32'h0010_03D0});
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      stepCycle();
      checkOutput("isolate_idle", {63'b0, divBus.ready_o}, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
